serv_csr_ctrl: RTL and testbench



---
 rtl/serv_csr_pkg.sv | 29 ++
 rtl/serv_ser_cnt.sv | 43 ++++
 rtl/serv_csr_ctrl.sv | 130 +++++++++++++
 tb/tb_serv_csr_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/serv_csr_pkg.sv
// Shared encodings for the CSR/trap sequencer.
//   op codes    : which request won arbitration (CSR access, mret, exception, interrupt)
//   select codes: which machine CSR an instruction access targets
//   state_e     : sequencer FSM states
package serv_csr_pkg;

  localparam logic [1:0] OP_CSR  = 2'd0;
  localparam logic [1:0] OP_MRET = 2'd1;
  localparam logic [1:0] OP_EXC  = 2'd2;
  localparam logic [1:0] OP_IRQ  = 2'd3;

  localparam logic [1:0] SEL_MSTATUS = 2'b00;
  localparam logic [1:0] SEL_MIE     = 2'b01;
  localparam logic [1:0] SEL_MCAUSE  = 2'b10;
  localparam logic [1:0] SEL_OTHER   = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StRun,
    StAck
  } state_e;

  // Exceptions and interrupts share the trap path (bit 1 of the op code).
  function automatic logic op_is_trap(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/serv_ser_cnt.sv
// Serial bit counter for one WIDTH-cycle pass.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : force count to zero
//   i_en         : advance the count; also qualifies every decoded output
//   o_wrap       : last cycle of a pass (count rolls over to 0 next)
//   o_cnt0to3, o_cnt3, o_cnt7, o_done : decoded count strobes
module serv_ser_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_wrap,
  output logic o_cnt0to3,
  output logic o_cnt3,
  output logic o_cnt7,
  output logic o_done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntMax = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;

  // WIDTH is a power of two, so the natural rollover lands exactly on the pass boundary.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_comb begin
    o_done    = i_en && (cnt_q == CntMax);
    o_wrap    = o_done;
    o_cnt0to3 = i_en && (cnt_q < CW'(4));
    o_cnt3    = i_en && (cnt_q == CW'(3));
    o_cnt7    = i_en && (cnt_q == CW'(7));
  end

endmodule

// File: rtl/serv_csr_ctrl.sv
// Bit-serial sequencer for the machine-mode CSR/trap datapath.
// Arbitrates CSR access, trap entry (exception or timer interrupt) and mret, then runs
// an optional init pass (traps only) followed by one run pass and a one-cycle ack.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_csr_req, i_csr_sel    : instruction CSR access and target select
//   i_exc_req, i_mret_req   : exception / mret requests, held until o_ack
//   i_new_irq               : one-cycle timer interrupt pulse
//   o_busy, o_ack, o_irq_taken : sequence status
//   o_en, o_init, o_cnt*    : serial datapath timing strobes
//   o_mstatus_en, o_mie_en, o_mcause_en, o_trap, o_mret : pass qualifiers
module serv_csr_ctrl
  import serv_csr_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_csr_req,
  input  logic [1:0] i_csr_sel,
  input  logic       i_exc_req,
  input  logic       i_mret_req,
  input  logic       i_new_irq,
  output logic       o_busy,
  output logic       o_ack,
  output logic       o_irq_taken,
  output logic       o_en,
  output logic       o_init,
  output logic       o_cnt0to3,
  output logic       o_cnt3,
  output logic       o_cnt7,
  output logic       o_cnt_done,
  output logic       o_mstatus_en,
  output logic       o_mie_en,
  output logic       o_mcause_en,
  output logic       o_trap,
  output logic       o_mret
);

  state_e     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] sel_q, sel_d;
  logic       irq_pend_q, irq_pend_d;
  logic       irq_req, accept_irq;
  logic       cnt_wrap;
  logic       run;

  // A pulse arriving while idle is served at once rather than a cycle later.
  assign irq_req    = irq_pend_q | i_new_irq;
  assign accept_irq = (state_q == StIdle) && irq_req;

  // A pulse that was itself accepted is consumed; a pulse landing on top of an
  // already-pending interrupt being accepted leaves a new one pending.
  assign irq_pend_d = (irq_pend_q && !accept_irq) ||
                      (i_new_irq && !(accept_irq && !irq_pend_q));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      op_q       <= OP_CSR;
      sel_q      <= SEL_MSTATUS;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (irq_req) begin
          op_d    = OP_IRQ;
          sel_d   = i_csr_sel;
          state_d = StInit;
        end else if (i_exc_req) begin
          op_d    = OP_EXC;
          sel_d   = i_csr_sel;
          state_d = StInit;
        end else if (i_mret_req) begin
          op_d    = OP_MRET;
          sel_d   = i_csr_sel;
          state_d = StRun;
        end else if (i_csr_req) begin
          op_d    = OP_CSR;
          sel_d   = i_csr_sel;
          state_d = StRun;
        end
      end
      StInit:  if (cnt_wrap) state_d = StRun;
      StRun:   if (cnt_wrap) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign run = (state_q == StRun);

  always_comb begin
    o_busy       = (state_q != StIdle);
    o_ack        = (state_q == StAck);
    o_irq_taken  = o_ack && (op_q == OP_IRQ);
    o_init       = (state_q == StInit);
    o_en         = o_init || run;
    o_mstatus_en = run && (op_q == OP_CSR) && (sel_q == SEL_MSTATUS);
    o_mie_en     = run && (op_q == OP_CSR) && (sel_q == SEL_MIE);
    o_mcause_en  = run && (op_q == OP_CSR) && (sel_q == SEL_MCAUSE);
    o_trap       = run && op_is_trap(op_q);
    o_mret       = run && (op_q == OP_MRET);
  end

  serv_ser_cnt #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (!o_en),
    .i_en     (o_en),
    .o_wrap   (cnt_wrap),
    .o_cnt0to3(o_cnt0to3),
    .o_cnt3   (o_cnt3),
    .o_cnt7   (o_cnt7),
    .o_done   (o_cnt_done)
  );

endmodule

// File: tb/tb_serv_csr_ctrl.sv
// Directed bench for serv_csr_ctrl: a 32-bit instance for the main scenarios and an
// 8-bit instance for the short-pass case. Outputs are packed into one vector per DUT
// and compared cycle by cycle against a timeline derived from the request kind.
module tb_serv_csr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       csr_req, exc_req, mret_req, new_irq;
  logic [1:0] csr_sel;
  logic       csr_req8;
  logic [1:0] csr_sel8;

  int n_checks = 0;
  int n_pass   = 0;

  // {busy, ack, irq_taken, en, init, cnt0to3, cnt3, cnt7, done, mstatus, mie, mcause,
  //  trap, mret}
  logic [13:0] obs32, obs8;
  logic b32, a32, it32, e32, i32, c03_32, c3_32, c7_32, d32, ms32, mi32, mc32, t32, m32;
  logic b8, a8, it8, e8, i8, c03_8, c3_8, c7_8, d8, ms8, mi8, mc8, t8, m8;

  always #5 clk = ~clk;

  serv_csr_ctrl #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_csr_req(csr_req), .i_csr_sel(csr_sel),
    .i_exc_req(exc_req), .i_mret_req(mret_req), .i_new_irq(new_irq),
    .o_busy(b32), .o_ack(a32), .o_irq_taken(it32), .o_en(e32), .o_init(i32),
    .o_cnt0to3(c03_32), .o_cnt3(c3_32), .o_cnt7(c7_32), .o_cnt_done(d32),
    .o_mstatus_en(ms32), .o_mie_en(mi32), .o_mcause_en(mc32), .o_trap(t32), .o_mret(m32)
  );

  serv_csr_ctrl #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_csr_req(csr_req8), .i_csr_sel(csr_sel8),
    .i_exc_req(1'b0), .i_mret_req(1'b0), .i_new_irq(1'b0),
    .o_busy(b8), .o_ack(a8), .o_irq_taken(it8), .o_en(e8), .o_init(i8),
    .o_cnt0to3(c03_8), .o_cnt3(c3_8), .o_cnt7(c7_8), .o_cnt_done(d8),
    .o_mstatus_en(ms8), .o_mie_en(mi8), .o_mcause_en(mc8), .o_trap(t8), .o_mret(m8)
  );

  assign obs32 = {b32, a32, it32, e32, i32, c03_32, c3_32, c7_32, d32, ms32, mi32, mc32,
                  t32, m32};
  assign obs8  = {b8, a8, it8, e8, i8, c03_8, c3_8, c7_8, d8, ms8, mi8, mc8, t8, m8};

  task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b want %b", tag, got, want);
  endtask

  // Sample one ns after the active edge: the view is of cycle n after n calls.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs in cycle n after a request of the given kind was accepted at n=0.
  // kind: 0 CSR, 1 mret, 2 exception, 3 interrupt.
  function automatic logic [13:0] exp_vec(input int kind, input logic [1:0] sel,
                                          input int n, input int w);
    int   base, c;
    logic trap, init, run, ack, en, busy;
    trap = (kind >= 2);
    base = trap ? w : 0;
    init = trap && n >= 1 && n <= w;
    run  = n >= base + 1 && n <= base + w;
    ack  = (n == base + w + 1);
    busy = n >= 1 && n <= base + w + 1;
    en   = init || run;
    c    = init ? n - 1 : (run ? n - base - 1 : 0);
    return {busy, ack, ack && kind == 3, en, init, en && c < 4, en && c == 3, en && c == 7,
            en && c == w - 1, run && kind == 0 && sel == 2'b00,
            run && kind == 0 && sel == 2'b01, run && kind == 0 && sel == 2'b10,
            run && trap, run && kind == 1};
  endfunction

  // Walk one full sequence including the idle cycle after the ack. The request for this
  // kind is dropped during its ack cycle; irq_at injects a one-cycle interrupt pulse.
  task automatic run_seq(input int kind, input logic [1:0] sel, input int w,
                         input int irq_at, input string tag);
    int last;
    last = (kind >= 2 ? 2 * w : w) + 1;
    for (int n = 1; n <= last + 1; n++) begin
      step();
      new_irq = 1'b0;
      if (n == irq_at) new_irq = 1'b1;
      check_eq($sformatf("%s_c%0d", tag, n), (w == 8) ? obs8 : obs32,
               exp_vec(kind, sel, n, w));
      if (n == last) begin
        case (kind)
          0: if (w == 8) csr_req8 = 1'b0; else csr_req = 1'b0;
          1: mret_req = 1'b0;
          2: exc_req = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    csr_req = 1'b0; exc_req = 1'b0; mret_req = 1'b0; new_irq = 1'b0;
    csr_sel = 2'b00; csr_req8 = 1'b0; csr_sel8 = 2'b00;
    step();
    step();
    check_eq("reset32", obs32, 14'd0);
    check_eq("reset8", obs8, 14'd0);
    rst = 1'b0;
    step();
    check_eq("idle32", obs32, 14'd0);

    // CSR access to mie.
    csr_req = 1'b1; csr_sel = 2'b01;
    run_seq(0, 2'b01, 32, 0, "csr_mie");

    // Exception trap.
    exc_req = 1'b1;
    run_seq(2, 2'b00, 32, 0, "exc");

    // All four at once: irq, exception, mret, CSR(mcause) in that order.
    new_irq = 1'b1; exc_req = 1'b1; mret_req = 1'b1; csr_req = 1'b1; csr_sel = 2'b10;
    run_seq(3, 2'b10, 32, 0, "pri_irq");
    run_seq(2, 2'b10, 32, 0, "pri_exc");
    run_seq(1, 2'b10, 32, 0, "pri_mret");
    run_seq(0, 2'b10, 32, 0, "pri_csr");

    // Interrupt pulse in cycle 15 of a CSR pass is held until the CSR op finishes.
    csr_req = 1'b1; csr_sel = 2'b00;
    run_seq(0, 2'b00, 32, 15, "busy_csr");
    run_seq(3, 2'b00, 32, 0, "busy_irq");

    // Eight-cycle pass, unbacked CSR select.
    csr_req8 = 1'b1; csr_sel8 = 2'b11;
    run_seq(0, 2'b11, 8, 0, "w8_other");

    // Reset during RUN at cnt=10 aborts with no ack.
    csr_req = 1'b1; csr_sel = 2'b00;
    for (int n = 1; n <= 11; n++) begin
      step();
      check_eq($sformatf("abort_c%0d", n), obs32, exp_vec(0, 2'b00, n, 32));
    end
    rst = 1'b1; csr_req = 1'b0;
    step();
    check_eq("abort_rst1", obs32, 14'd0);
    step();
    check_eq("abort_rst2", obs32, 14'd0);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      check_eq($sformatf("abort_idle%0d", n), obs32, 14'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
